// File: rtl/spi_pkg.sv
// Shared SPI frame constants and master FSM state encoding.
// The slave side may import FRAME_BITS as well.
package spi_pkg;
  localparam int FRAME_BITS = 32;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    SHIFT,
    TRAIL,
    DONE
  } spi_state_t;
endpackage

// File: rtl/spi_master_tx_if.sv
// Request/response and SPI pin bundle for spi_master_tx.
// A frame is accepted on a clk edge with start=1 and ready=1; done pulses one cycle with rx_data valid.
interface spi_master_tx_if;
  import spi_pkg::*;

  logic                  start;
  logic [FRAME_BITS-1:0] tx_data;
  logic                  ready;
  logic [FRAME_BITS-1:0] rx_data;
  logic                  done;
  logic                  sck;
  logic                  sdo;
  logic                  sdi;
  logic                  ss_n;
  spi_state_t            state;

  modport master (
    input  start, tx_data, sdi,
    output ready, rx_data, done, sck, sdo, ss_n, state
  );

  modport slave (
    output start, tx_data, sdi,
    input  ready, rx_data, done, sck, sdo, ss_n, state
  );
endinterface

// File: rtl/spi_clk_gen.sv
// Half-period divider: one-cycle tick at terminal count while enabled.
module spi_clk_gen #(
  parameter int HALF_PERIOD = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clear,
  output logic tick
);
  localparam int DW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [DW-1:0] TERM = DW'(HALF_PERIOD - 1);

  logic [DW-1:0] div;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div <= '0;
    end else if (clear) begin
      div <= '0;
    end else if (en) begin
      div <= (div == TERM) ? '0 : div + DW'(1);
    end
  end

  assign tick = en && (div == TERM);
endmodule

// File: rtl/spi_master_tx.sv
// Mode-0 SPI master: one 32-bit full-duplex frame per accepted request, MSB first.
// All outputs are registered except sdo, which is the MSB of the transmit shifter.
module spi_master_tx
  import spi_pkg::*;
#(
  parameter int HALF_PERIOD = 4
) (
  input  logic            clk,
  input  logic            reset,
  spi_master_tx_if.master bus
);
  spi_state_t            state, state_next;
  logic                  tick, accept, rise, fall;
  logic                  sck_q, ss_n_q, ready_q, done_q;
  logic [FRAME_BITS-1:0] tx_shift, rx_shift, rx_q;
  logic [5:0]            bit_cnt;

  spi_clk_gen #(.HALF_PERIOD(HALF_PERIOD)) u_clk_gen (
    .clk   (clk),
    .reset (reset),
    .en    (state != IDLE && state != DONE),
    .clear (accept),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // The LEAD terminal count is the first rising edge; SHIFT alternates fall/rise from there.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    rise       = 1'b0;
    fall       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && ready_q) begin
          accept     = 1'b1;
          state_next = LEAD;
        end
      end
      LEAD: begin
        if (tick) begin
          rise       = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          rise = !sck_q;
          fall = sck_q;
          if (sck_q && bit_cnt == 6'(FRAME_BITS - 1)) state_next = TRAIL;
        end
      end
      TRAIL: begin
        if (tick) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_q    <= 1'b0;
      ss_n_q   <= 1'b1;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      tx_shift <= '0;
      rx_shift <= '0;
      rx_q     <= '0;
      bit_cnt  <= '0;
    end else begin
      ready_q <= (state_next == IDLE);
      ss_n_q  <= (state_next == IDLE) || (state_next == DONE);
      done_q  <= (state_next == DONE);
      if (accept) begin
        tx_shift <= bus.tx_data;
        bit_cnt  <= '0;
      end
      if (rise) begin
        sck_q    <= 1'b1;
        rx_shift <= {rx_shift[FRAME_BITS-2:0], bus.sdi};
      end
      if (fall) begin
        sck_q    <= 1'b0;
        tx_shift <= {tx_shift[FRAME_BITS-2:0], 1'b0};
        bit_cnt  <= bit_cnt + 6'd1;
      end
      if (state_next == DONE) begin
        rx_q  <= rx_shift;
        sck_q <= 1'b0;
      end
    end
  end

  assign bus.ready   = ready_q;
  assign bus.done    = done_q;
  assign bus.rx_data = rx_q;
  assign bus.sck     = sck_q;
  assign bus.ss_n    = ss_n_q;
  assign bus.sdo     = tx_shift[FRAME_BITS-1];
  assign bus.state   = state;
endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: loopback and a behavioural 32-edge frame-counting slave,
// with rx_data and slave-received words checked against expected queues.
module tb_spi_master_tx;
  import spi_pkg::*;

  localparam int HP = 4;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  spi_master_tx_if bus();

  spi_master_tx #(.HALF_PERIOD(HP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] slv_q[$];

  int cyc = 0;
  int rise_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int accept_cyc = 0;
  logic sdo_seen = 1'b0;

  // slave model: presents d MSB first, changes on sck fall, samples on sck rise
  logic        loopback = 1'b1;
  logic [31:0] slave_d = 32'h0;
  logic [4:0]  scnt = 5'd0;
  logic [31:0] s_rx = 32'h0;

  assign bus.sdi = loopback ? bus.sdo : slave_d[5'd31 - scnt];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;
  always @(posedge bus.sck) rise_cnt++;

  always @(posedge bus.sck or posedge reset) begin
    if (reset) s_rx = 32'h0;
    else       s_rx = {s_rx[30:0], bus.sdo};
  end

  always @(negedge bus.sck or posedge reset) begin
    if (reset) begin
      scnt = 5'd0;
    end else begin
      if (scnt == 5'd31) begin
        if (slv_q.size() == 0) begin
          total++; bad++;
          $display("FAIL slave_q: got %h expected none", s_rx);
        end else begin
          check("slave_q", s_rx, slv_q.pop_front());
        end
      end
      scnt = scnt + 5'd1;
    end
  end

  // monitor
  always @(negedge clk) begin
    if (bus.sdo) sdo_seen = 1'b1;
    if (bus.done) begin
      done_cnt++;
      done_cyc = cyc;
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL rx_data: got %h expected no done", bus.rx_data);
      end else begin
        check("rx_data", bus.rx_data, exp_q.pop_front());
      end
    end
  end

  // driver tasks (called at a negedge)
  task automatic wait_ready();
    int n = 0;
    while (!bus.ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready) begin
      total++; bad++;
      $display("FAIL ready_timeout: got 0 expected 1");
    end
  endtask

  task automatic send(input logic [31:0] w, input logic [31:0] exp_rx);
    wait_ready();
    bus.start   = 1'b1;
    bus.tx_data = w;
    exp_q.push_back(exp_rx);
    slv_q.push_back(w);
    @(negedge clk);
    bus.start  = 1'b0;
    accept_cyc = cyc;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 1000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("done_count", 32'(done_cnt), 32'(target));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_sck"},   32'(bus.sck),   32'd0);
    check({tag, "_sdo"},   32'(bus.sdo),   32'd0);
    check({tag, "_ss_n"},  32'(bus.ss_n),  32'd1);
    check({tag, "_ready"}, 32'(bus.ready), 32'd1);
    check({tag, "_done"},  32'(bus.done),  32'd0);
    check({tag, "_rx"},    bus.rx_data,    32'h0);
    check({tag, "_state"}, 32'(bus.state), 32'(IDLE));
  endtask

  initial begin
    int r0, n, cnt_r, cnt_s, dones, d0;
    logic drop_next;
    bus.start   = 1'b0;
    bus.tx_data = 32'h0;

    // reset values
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_idle("reset");

    // loopback frame: 32 rises, done 260 cycles after accept
    loopback = 1'b1;
    r0 = rise_cnt;
    send(32'hA5C30F81, 32'hA5C30F81);
    wait_done(1);
    check("rise_count", 32'(rise_cnt - r0), 32'd32);
    check("done_latency", 32'(done_cyc - accept_cyc), 32'(65 * HP));

    // against the slave model
    loopback = 1'b0;
    slave_d  = 32'h12345678;
    send(32'h000003FF, 32'h12345678);
    wait_done(2);

    // start held high: back-to-back frames
    wait_ready();
    bus.start   = 1'b1;
    bus.tx_data = 32'h1;
    exp_q.push_back(32'h12345678); slv_q.push_back(32'h1);
    exp_q.push_back(32'h12345678); slv_q.push_back(32'h2);
    @(negedge clk);
    bus.tx_data = 32'h2;
    cnt_r = 0; cnt_s = 0; dones = 0; n = 0; drop_next = 1'b0;
    while (dones < 2 && n < 1500) begin
      if (bus.done) dones++;
      if (dones < 2) begin
        if (bus.ready) cnt_r++;
        if (bus.ss_n) cnt_s++;
        if (bus.ready) drop_next = 1'b1;
        else if (drop_next) begin
          bus.start = 1'b0;
          drop_next = 1'b0;
        end
        @(negedge clk);
        n++;
      end
    end
    bus.start = 1'b0;
    check("b2b_ready_cycles", 32'(cnt_r), 32'd1);
    check("b2b_ss_n_cycles", 32'(cnt_s), 32'd2);
    wait_done(4);

    // start during SHIFT is ignored
    loopback = 1'b1;
    sdo_seen = 1'b0;
    send(32'h0, 32'h0);
    repeat (100) @(negedge clk);
    check("shift_state", 32'(bus.state), 32'(SHIFT));
    bus.start   = 1'b1;
    bus.tx_data = 32'hFFFFFFFF;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(5);
    repeat (300) @(negedge clk);
    check("ignored_done_count", 32'(done_cnt), 32'd5);
    check("ignored_sdo", 32'(sdo_seen), 32'd0);

    // reset after the 10th rise, then a clean frame
    loopback = 1'b0;
    slave_d  = 32'hCAFEF00D;
    wait_ready();
    r0 = rise_cnt;
    bus.start   = 1'b1;
    bus.tx_data = 32'hAAAA5555;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (rise_cnt - r0 < 10 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("rises_before_reset", 32'(rise_cnt - r0), 32'd10);
    d0 = done_cnt;
    reset = 1'b1;
    @(negedge clk);
    check_idle("midreset");
    reset = 1'b0;
    repeat (300) @(negedge clk);
    check("no_done_after_reset", 32'(done_cnt), 32'(d0));
    send(32'hDEADBEEF, 32'hCAFEF00D);
    wait_done(d0 + 1);

    check("exp_q_left", 32'(exp_q.size()), 32'd0);
    check("slv_q_left", 32'(slv_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_master_tx.md
# spi_master_tx

SPI master that generates `sck` and transfers one 32-bit full-duplex frame per request, MSB first. It drives the FPGA's heart-rate-monitor SPI link from the master end: it shifts `tx_data` out on `sdo` and captures the word returned on `sdi`. It is bit-compatible with the existing 32-edge, frame-counting SPI slave: mode 0, sample on `sck` rise, change on `sck` fall, no chip-select dependence. It sits between the filter/peak-detect logic and the off-chip or loopback SPI pins.

## Interface
- `HALF_PERIOD`, 4: `clk` cycles per `sck` half period. Must be ≥1.
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high; returns the block to IDLE.
- `start`  in  1  request a frame. Accepted only when `ready`=1.
- `tx_data`  in  32  word to send. Latched on accept.
- `ready`  out  1  high only in IDLE.
- `rx_data`  out  32  last received word. Updated in the DONE cycle and held until the next DONE.
- `done`  out  1  one-cycle pulse; `rx_data` is valid in the same cycle.
- `sck`  out  1  serial clock. Idles low (CPOL=0).
- `sdo`  out  1  master-out data. Idles 0.
- `sdi`  in  1  master-in data from the slave.
- `ss_n`  out  1  frame-active strobe, low from LEAD through TRAIL.

## Operation
- States:
  - IDLE → LEAD on `start`&`ready`.
  - LEAD → SHIFT after `HALF_PERIOD` cycles.
  - SHIFT → TRAIL after the 32nd `sck` fall.
  - TRAIL → DONE after `HALF_PERIOD` cycles.
  - DONE → IDLE unconditionally.
- Accept: `tx_shift`←`tx_data`, bit counter←0, divider←0, `ss_n`←0. `sdo` equals `tx_shift[31]` combinationally from this point.
- Divider counts 0..`HALF_PERIOD`-1. In LEAD, terminal count ends LEAD with `sck`←1. In SHIFT, each terminal count toggles `sck`.
- Rising toggle: `rx_shift`←{`rx_shift[30:0]`, `sdi`}. `sdi` is sampled at the same `clk` edge that raises `sck`.
- Falling toggle: `tx_shift`←{`tx_shift[30:0]`, 0} and bit counter +1. Every frame produces exactly 32 rises and 32 falls; the slave's 5-bit counter depends on this.
- After the 32nd fall, `sdo`=0 (shifted-in zero) throughout TRAIL.
- DONE: `rx_data`←`rx_shift`, `done`=1, `ss_n`=1, `sck`=0.
- `start` while not ready is ignored, with no queuing. `tx_data` changes after accept are ignored.
- `start` held high produces back-to-back frames: `ready` is high for exactly one cycle between them, and `ss_n` is high for 2 cycles (DONE, IDLE).
- Reset mid-frame: all registers return to reset values at once and no `done` pulse is issued. The slave must share `reset` to stay frame-aligned; this is a system-level requirement, not handled here.

## Timing
- Reset values: `sck`=0, `sdo`=0, `ss_n`=1, `ready`=1, `done`=0, `rx_data`=0, state IDLE.
- Let E0 be the accept edge:
  - first `sck` rise at E0+HP;
  - rise k (1..32) at E0+(2k−1)·HP;
  - fall k at E0+2k·HP;
  - DONE entered at E0+65·HP (`done` high in the following cycle);
  - IDLE at E0+65·HP+1.
- Frame length is 65·HP+1 cycles from accept to the next possible accept. HP=4 gives 261.
- `sdo` changes only at a fall edge or at accept, so it is stable for ≥HP cycles before each rise.
- Widths:
  - bit counter 6 bits (0..32);
  - divider `$clog2(HALF_PERIOD)`, minimum 1 bit;
  - no arithmetic on data.

## Structure
- Package `spi_pkg`: `FRAME_BITS`=32 localparam and a `spi_state_t` enum {IDLE, LEAD, SHIFT, TRAIL, DONE}. The slave may later import `FRAME_BITS`.
- Sub-module `spi_clk_gen`: the divider, producing a one-cycle `tick` at terminal count, enabled only outside IDLE/DONE and cleared on accept.
- FSM, shift registers and output registers stay in `spi_master_tx`. All outputs are registered except `sdo`, which is taken directly from `tx_shift[31]`.

## Test plan
- Reset asserted mid-run → next cycle: `sck`=0, `sdo`=0, `ss_n`=1, `ready`=1, `done`=0, `rx_data`=0.
- Loopback `sdo`→`sdi`, HP=4, `tx_data`=0xA5C30F81 → exactly 32 `sck` rises, `done` high in the cycle after E0+260, `rx_data`=0xA5C30F81.
- Against the SPI slave model with `d`=0x12345678, send 0x000003FF → slave `q`=0x000003FF, master `rx_data`=0x12345678.
- `start` held high, `tx_data` 0x1 then 0x2 → two frames, `ready` high for one cycle between them, `ss_n` high for 2 cycles, slave receives 0x1 then 0x2.
- `start` pulsed with 0xFFFFFFFF during SHIFT of a frame carrying 0x0 → ignored, `sdo` stays 0 all frame, single `done`.
- Reset after the 10th `sck` rise → idle values next cycle, no `done`. Reset the slave too, then a frame with 0xDEADBEEF → `rx_data`/slave `q` correct.
